// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Optional round-robin arbitration: define MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Backing-memory bus: req held until a one-cycle ack.
// Arbiter drives as master, memory responds as slave.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output rdata, ack
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane formatting for stores and load extraction.
// Purely combinational; flags misaligned or undefined modes.
module mem_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]      mode,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_sh,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign
);

  logic [XLEN-1:0] rsh;

  // Lane shift/strobe for stores, extract/extend for loads
  always_comb begin
    rsh       = rdata >> {addr_lo, 3'b000};
    wdata_sh  = '0;
    wstrb     = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    unique case (mode)
      MEM_B, MEM_BU: begin
        wdata_sh  = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = (mode == MEM_B) ?
                    {{24{rsh[7]}}, rsh[7:0]} :
                    {24'b0, rsh[7:0]};
      end
      MEM_H, MEM_HU: begin
        misalign  = addr_lo[0];
        wdata_sh  = {16'b0, wdata[15:0]} << {addr_lo[1], 4'b0000};
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext = (mode == MEM_H) ?
                    {{16{rsh[15]}}, rsh[15:0]} :
                    {16'b0, rsh[15:0]};
      end
      MEM_W: begin
        misalign  = |addr_lo;
        wdata_sh  = wdata;
        wstrb     = 4'b1111;
        rdata_ext = rsh;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and MEM-stage (D) over one memory bus.
// Define MEM_ARB_RR_EN for round-robin, else D has priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [2:0]      d_mode,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            d_err,
  mem_arbiter_if.master   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  arb_state_e      state;
  logic [CW-1:0]   tcnt;
  logic [2:0]      cur_mode;
  logic [1:0]      cur_lo;
  logic            cur_bad;
  logic            grant_d;
  logic            grant_i;
  logic [2:0]      al_mode;
  logic [1:0]      al_lo;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_rdata;
  logic            al_bad;
  logic            unused_ok;

  assign unused_ok = ^i_addr[1:0];

  // Format from live inputs at grant, from latched copy after
  assign al_mode = (state == IDLE) ? d_mode : cur_mode;
  assign al_lo   = (state == IDLE) ? d_addr[1:0] : cur_lo;

  mem_align u_align (
    .mode      (al_mode),
    .addr_lo   (al_lo),
    .wdata     (d_wdata),
    .rdata     (bus.rdata),
    .wdata_sh  (al_wdata),
    .wstrb     (al_wstrb),
    .rdata_ext (al_rdata),
    .misalign  (al_bad)
  );

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // Remember which side won the most recent grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_d)      last_d <= 1'b1;
      else if (grant_i) last_d <= 1'b0;
    end
  end

  assign grant_d = d_req & ~(i_req & last_d);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_req & ~grant_d;

  // Grant, bus transaction, timeout abort and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      cur_mode  <= '0;
      cur_lo    <= '0;
      cur_bad   <= 1'b0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.wstrb <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_d) begin
            state     <= GNT_D;
            cur_mode  <= d_mode;
            cur_lo    <= d_addr[1:0];
            cur_bad   <= al_bad;
            bus.req   <= ~al_bad;
            bus.we    <= d_we & ~al_bad;
            bus.addr  <= {d_addr[XLEN-1:2], 2'b00};
            bus.wdata <= d_we ? al_wdata : '0;
            bus.wstrb <= (d_we & ~al_bad) ? al_wstrb : 4'b0;
          end else if (grant_i) begin
            state     <= GNT_I;
            bus.req   <= 1'b1;
            bus.we    <= 1'b0;
            bus.addr  <= {i_addr[XLEN-1:2], 2'b00};
            bus.wdata <= '0;
            bus.wstrb <= 4'b0;
          end
        end
        GNT_I: begin
          if (bus.ack) begin
            state   <= RESP;
            bus.req <= 1'b0;
            i_done  <= 1'b1;
            i_rdata <= bus.rdata;
          end else if (tcnt == TLAST) begin
            state   <= RESP;
            bus.req <= 1'b0;
            i_done  <= 1'b1;
            i_rdata <= NOP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        GNT_D: begin
          if (cur_bad) begin
            state   <= RESP;
            d_done  <= 1'b1;
            d_err   <= 1'b1;
            d_rdata <= '0;
          end else if (bus.ack) begin
            state     <= RESP;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.wstrb <= 4'b0;
            d_done    <= 1'b1;
            d_rdata   <= bus.we ? '0 : al_rdata;
          end else if (tcnt == TLAST) begin
            state     <= RESP;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.wstrb <= 4'b0;
            d_done    <= 1'b1;
            d_err     <= 1'b1;
            d_rdata   <= '0;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: loads, stores, arbitration,
// misalignment, timeout and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_mode  (d_mode),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        ack_en;
  logic        late_ack;
  logic [31:0] rd_word;
  int          req_cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks the first cycle it sees bus_req
  always @(posedge clk) begin
    #1;
    if (bus.req) req_cnt++;
    if (bus.req && ack_en && !bus.ack) begin
      bus.ack   = 1'b1;
      bus.rdata = rd_word;
      cap_addr  = bus.addr;
      cap_wdata = bus.wdata;
      cap_wstrb = bus.wstrb;
      cap_we    = bus.we;
    end else begin
      bus.ack   = late_ack;
      bus.rdata = rd_word;
    end
  end

  task automatic d_op(input logic we, input logic [2:0] mode,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd,
                      output logic err);
    d_req = 1'b1; d_we = we; d_mode = mode;
    d_addr = addr; d_wdata = wd; lat = 0;
    do begin
      @(posedge clk); #2; lat++;
    end while (!d_done && lat < 400);
    rd = d_rdata; err = d_err; d_req = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic i_op(input logic [31:0] addr,
                      output int lat, output logic [31:0] rd);
    i_req = 1'b1; i_addr = addr; lat = 0;
    do begin
      @(posedge clk); #2; lat++;
    end while (!i_done && lat < 400);
    rd = i_rdata; i_req = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({bus.req, bus.we, i_done, d_done, d_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
               {bus.req, bus.we, i_done, d_done, d_err});
    end
    checks++;
    if (bus.addr !== 32'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h %h %h want 0 0 0",
               bus.addr, bus.wdata, bus.wstrb);
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h want 0 0", i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_lw();
    int lat; logic [31:0] rd; logic err;
    rd_word = 32'hDEADBEEF;
    d_op(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, err);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL lw_latency: got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL lw_data: got %h err %b want deadbeef err 0", rd, err);
    end
    checks++;
    if (cap_addr !== 32'h100 || cap_we !== 1'b0 || cap_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL lw_bus: got %h we %b strb %b want 00000100 0 0000",
               cap_addr, cap_we, cap_wstrb);
    end
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic err;
    rd_word = 32'h80FFFFFF;
    d_op(1'b0, 3'b000, 32'h103, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb: got %h want ffffff80", rd);
    end
    d_op(1'b0, 3'b100, 32'h103, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got %h want 00000080", rd);
    end
    rd_word = 32'h80011234;
    d_op(1'b0, 3'b001, 32'h102, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh: got %h want ffff8001", rd);
    end
    d_op(1'b0, 3'b101, 32'h102, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00008001) begin
      errors++; $display("FAIL lhu: got %h want 00008001", rd);
    end
    d_op(1'b0, 3'b001, 32'h100, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00001234) begin
      errors++; $display("FAIL lh_lo: got %h want 00001234", rd);
    end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic err;
    d_op(1'b1, 3'b001, 32'h102, 32'h00001234, lat, rd, err);
    checks++;
    if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'h12340000) begin
      errors++;
      $display("FAIL sh: got strb %b data %h want 1100 12340000", cap_wstrb, cap_wdata);
    end
    checks++;
    if (cap_we !== 1'b1 || cap_addr !== 32'h100 || lat !== 2) begin
      errors++;
      $display("FAIL sh_bus: got we %b addr %h lat %0d want 1 00000100 2",
               cap_we, cap_addr, lat);
    end
    d_op(1'b1, 3'b000, 32'h101, 32'hFFFFFFAB, lat, rd, err);
    checks++;
    if (cap_wstrb !== 4'b0010 || cap_wdata !== 32'h0000AB00) begin
      errors++;
      $display("FAIL sb: got strb %b data %h want 0010 0000ab00", cap_wstrb, cap_wdata);
    end
    d_op(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, lat, rd, err);
    checks++;
    if (cap_wstrb !== 4'b1111 || cap_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL sw: got strb %b data %h want 1111 cafef00d", cap_wstrb, cap_wdata);
    end
  endtask

  task automatic test_misalign();
    int lat; int c0; logic [31:0] rd; logic err;
    logic [2:0] modes [3];
    logic [31:0] addrs [3];
    modes[0] = 3'b010; addrs[0] = 32'h101;
    modes[1] = 3'b001; addrs[1] = 32'h103;
    modes[2] = 3'b011; addrs[2] = 32'h100;
    rd_word = 32'h55555555;
    for (int k = 0; k < 3; k++) begin
      c0 = req_cnt;
      d_op(1'b0, modes[k], addrs[k], 32'h0, lat, rd, err);
      checks++;
      if (lat !== 2 || err !== 1'b1 || rd !== 32'h0 || req_cnt !== c0) begin
        errors++;
        $display("FAIL misalign_%0d: got lat %0d err %b rd %h reqs %0d want 2 1 0 0",
                 k, lat, err, rd, req_cnt - c0);
      end
    end
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] rd;
    rd_word = 32'h00500093;
    i_op(32'h40, lat, rd);
    checks++;
    if (lat !== 2 || rd !== 32'h00500093 || cap_addr !== 32'h40) begin
      errors++;
      $display("FAIL fetch: got lat %0d rd %h addr %h want 2 00500093 00000040",
               lat, rd, cap_addr);
    end
  endtask

  task automatic test_arbitration();
    int lat_i; int lat_d; int n;
    int lat; logic [31:0] rd; logic err;
    rd_word = 32'h11223344;
    d_op(1'b0, 3'b010, 32'h300, 32'h0, lat, rd, err);
    lat_i = 0; lat_d = 0; n = 0;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b010; d_addr = 32'h304;
    while ((i_req || d_req) && n < 40) begin
      @(posedge clk); #2; n++;
      if (d_done) begin lat_d = n; d_req = 1'b0; end
      if (i_done) begin lat_i = n; i_req = 1'b0; end
    end
    @(posedge clk); #2;
`ifdef MEM_ARB_RR_EN
    checks++;
    if (lat_i !== 2 || lat_d !== 5) begin
      errors++; $display("FAIL arb_rr: got i %0d d %0d want i 2 d 5", lat_i, lat_d);
    end
`else
    checks++;
    if (lat_d !== 2 || lat_i !== 5) begin
      errors++; $display("FAIL arb_fixed: got d %0d i %0d want d 2 i 5", lat_d, lat_i);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n; int t1; int t2;
    rd_word = 32'hA5A5A5A5;
    n = 0; t1 = 0; t2 = 0;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b010; d_addr = 32'h100;
    while (t2 == 0 && n < 40) begin
      @(posedge clk); #2; n++;
      if (d_done && t1 == 0) begin t1 = n; d_addr = 32'h104; end
      else if (d_done) begin t2 = n; d_req = 1'b0; end
    end
    d_req = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (t1 !== 2 || t2 !== 5 || cap_addr !== 32'h104) begin
      errors++;
      $display("FAIL back_to_back: got %0d %0d addr %h want 2 5 00000104",
               t1, t2, cap_addr);
    end
  endtask

  task automatic test_withdraw();
    int n; int t;
    rd_word = 32'h0BADF00D;
    n = 0; t = 0;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b010; d_addr = 32'h140;
    @(posedge clk); #2; n++;
    d_req = 1'b0;
    while (t == 0 && n < 20) begin
      @(posedge clk); #2; n++;
      if (d_done) t = n;
    end
    checks++;
    if (t !== 2 || d_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL withdraw: got lat %0d rd %h want 2 0badf00d", t, d_rdata);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_timeout();
    int lat; int c0; int stray; logic [31:0] rd; logic err;
    ack_en = 1'b0;
    c0 = req_cnt;
    d_op(1'b0, 3'b010, 32'h180, 32'h0, lat, rd, err);
    checks++;
    if (lat !== 256 || err !== 1'b1 || req_cnt - c0 !== 255) begin
      errors++;
      $display("FAIL d_timeout: got lat %0d err %b reqs %0d want 256 1 255",
               lat, err, req_cnt - c0);
    end
    late_ack = 1'b1;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      late_ack = 1'b0;
      if (d_done || i_done || bus.req) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL late_ack: got %0d stray cycles want 0", stray);
    end
    i_op(32'h1C0, lat, rd);
    checks++;
    if (lat !== 256 || rd !== 32'h00000013) begin
      errors++; $display("FAIL i_timeout: got lat %0d rd %h want 256 00000013", lat, rd);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int stray; int lat; logic [31:0] rd; logic err;
    ack_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_mode = 3'b010; d_addr = 32'h1A0;
    repeat (3) begin @(posedge clk); #2; end
    checks++;
    if (bus.req !== 1'b1) begin
      errors++; $display("FAIL mid_req: got %b want 1", bus.req);
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus.req !== 1'b0 || d_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got req %b done %b want 0 0", bus.req, d_done);
    end
    d_req = 1'b0; rst_n = 1'b1; ack_en = 1'b1;
    stray = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (d_done || bus.req) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL post_reset: got %0d stray cycles want 0", stray);
    end
    rd_word = 32'h76543210;
    d_op(1'b0, 3'b010, 32'h1A4, 32'h0, lat, rd, err);
    checks++;
    if (lat !== 2 || rd !== 32'h76543210) begin
      errors++; $display("FAIL recover: got lat %0d rd %h want 2 76543210", lat, rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_mode = '0;
    d_addr = '0; d_wdata = '0;
    ack_en = 1'b1; late_ack = 1'b0; rd_word = '0;
    req_cnt = 0;
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
    test_reset();
    test_lw();
    test_loads();
    test_store();
    test_misalign();
    test_fetch();
    test_arbitration();
    test_back_to_back();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
